// File: rtl/wb_stage_pipe.sv
// Registered write-back stage: ALU/memory select, optional sub-word load extraction,
// LAT-deep freeze/flush pipeline and committed-write counter. Option macro: WB_SUBWORD_LOAD_EN.
module wb_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned LAT    = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              mem_r_en,
  input  logic              wb_enable,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_res,
  input  logic [ADDR_W-1:0] dest,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_enable_out,
  output logic [ADDR_W-1:0] wb_dest_out,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  commit_cnt
);

  if (LAT < 1 || LAT > 4) begin : gen_lat_chk
    $error("wb_stage_pipe: LAT must be in 1..4");
  end

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] sel;

`ifdef WB_SUBWORD_LOAD_EN
  if (DATA_W < 32) begin : gen_width_chk
    $error("wb_stage_pipe: sub-word loads need DATA_W >= 32");
  end

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  always_comb begin
    half_lane = addr_lo[1] ? mem_res[31:16] : mem_res[15:0];
    byte_lane = mem_res[8*addr_lo +: 8];
    case (ld_size)
      2'b01:   ext = {{(DATA_W-16){ld_signed & half_lane[15]}}, half_lane};
      2'b10:   ext = {{(DATA_W-8){ld_signed & byte_lane[7]}}, byte_lane};
      default: ext = mem_res;
    endcase
  end
`else
  logic unused_subword;
  assign unused_subword = ^{ld_size, ld_signed, addr_lo};
  assign ext = mem_res;
`endif

  assign sel = mem_r_en ? ext : alu_res;

  logic [LAT-1:0]             vld_q, vld_d;
  logic [LAT-1:0]             wen_q, wen_d;
  logic [LAT-1:0][ADDR_W-1:0] dst_q, dst_d;
  logic [LAT-1:0][DATA_W-1:0] val_q, val_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  // Flush only drops valid bits; payload holds since it is masked by valid.
  always_comb begin
    vld_d = vld_q;
    wen_d = wen_q;
    dst_d = dst_q;
    val_d = val_q;
    cnt_d = cnt_q;
    if (flush) begin
      vld_d = '0;
    end else if (!freeze) begin
      vld_d[0] = in_valid;
      wen_d[0] = wb_enable;
      dst_d[0] = dest;
      val_d[0] = sel;
      for (int k = 1; k < LAT; k++) begin
        vld_d[k] = vld_q[k-1];
        wen_d[k] = wen_q[k-1];
        dst_d[k] = dst_q[k-1];
        val_d[k] = val_q[k-1];
      end
      if (wb_enable_out) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      wen_q <= '0;
      dst_q <= '0;
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wen_q <= wen_d;
      dst_q <= dst_d;
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

  assign wb_valid      = vld_q[LAT-1];
  assign wb_enable_out = vld_q[LAT-1] & wen_q[LAT-1];
  assign wb_dest_out   = dst_q[LAT-1];
  assign wb_value      = val_q[LAT-1];
  assign commit_cnt    = cnt_q;

endmodule

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised, registered write-back stage for the ARM pipeline. It takes the MEM-stage result bundle and selects between ALU and memory data. It can also extract and extend byte/halfword loads. The result passes through a configurable number of pipeline registers with freeze and flush control, and is presented to the register file together with a committed-write counter.

## Interface

Parameters:
- `DATA_W`, 32, data width of ALU/memory results and write-back value.
- `ADDR_W`, 4, register-file address width.
- `LAT`, 1, number of register stages between input and output, legal range 1 to 4.
- `CNT_W`, 32, width of the committed-write counter.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `freeze` input 1: hold all stages and the counter.
- `flush` input 1: invalidate all stages.
- `in_valid` input 1: input bundle is a real instruction.
- `mem_r_en` input 1: 1 selects memory data, 0 selects ALU result.
- `wb_enable` input 1: instruction writes a register.
- `alu_res` input DATA_W: ALU result.
- `mem_res` input DATA_W: memory read word.
- `dest` input ADDR_W: destination register.
- `ld_size` input 2: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- `ld_signed` input 1: sign-extend sub-word loads.
- `addr_lo` input 2: low address bits for lane selection.
- `wb_value` output DATA_W: value to write.
- `wb_enable_out` output 1: register-file write strobe.
- `wb_dest_out` output ADDR_W: register-file write address.
- `wb_valid` output 1: output stage holds a valid instruction.
- `commit_cnt` output CNT_W: number of committed register writes.

## Operation

- Selection is combinational on the input side: `sel = mem_r_en ? extract(mem_res) : alu_res`.
- Stage 1 captures {`in_valid`, `wb_enable`, `dest`, `sel`}. Stage k+1 captures stage k.
- Outputs are driven from stage LAT:
  - `wb_valid` = stage valid.
  - `wb_enable_out` = stage valid AND stage wb_enable.
  - `wb_dest_out` and `wb_value` are the stage fields.
- Sub-word extraction, only when the feature is compiled in (see Configuration):
  - Halfword: lane is `mem_res[15:0]` if `addr_lo[1]`=0, else `mem_res[31:16]`.
  - Byte: lane is byte `addr_lo` of `mem_res`.
  - Extension: zero-extend, or sign-extend when `ld_signed`=1.
  - `addr_lo[0]` is ignored for halfwords.
- Per-edge priority:
  - `rst`: all valid bits, data fields, outputs and `commit_cnt` are cleared to 0.
  - else `flush`: all valid bits are cleared. Data fields may load or hold, but their value is don't-care because valid=0. The counter holds.
  - else `freeze`: all stages and the counter hold.
  - else: stages advance. `commit_cnt` increments by 1 if `wb_enable_out`=1 before the edge.
- `commit_cnt` wraps modulo 2^CNT_W.
- `wb_enable` with `in_valid`=0 never produces a write.

## Timing

- Latency is exactly LAT cycles from an input sampled at an edge with `freeze`=0 to the corresponding output.
- Throughput is one instruction per cycle.
- Under `freeze`, outputs remain stable. Repeated register-file writes of the same value are permitted.
- `flush` takes effect at the edge where it is sampled high: `wb_valid` and `wb_enable_out` read 0 in the following cycle.
  - The instruction presented at the input during that cycle is also discarded.
- When `flush` and `freeze` are high together, flush wins.
- Reset mid-stream discards every in-flight instruction. `commit_cnt` returns to 0.
- Reset values:
  - `wb_value` = 0
  - `wb_enable_out` = 0
  - `wb_dest_out` = 0
  - `wb_valid` = 0
  - `commit_cnt` = 0
- LAT outside 1 to 4 is an elaboration error.

## Configuration

- Macro: `WB_SUBWORD_LOAD_EN`.
- Defined: byte/halfword extraction as described, using `ld_size`, `ld_signed` and `addr_lo`.
- Undefined:
  - `extract(mem_res) = mem_res`.
  - `ld_size`, `ld_signed` and `addr_lo` are ignored and unused.
  - Behaviour is identical to defined mode with `ld_size`=00.

## Test plan

- Reset, then an ALU writeback:
  - Stimulus: LAT=1, `in_valid`=1, `wb_enable`=1, `mem_r_en`=0, `alu_res`=0x0000_1234, `dest`=5.
  - Response one cycle later: `wb_value`=0x1234, `wb_dest_out`=5, `wb_enable_out`=1.
  - On the next edge `commit_cnt` becomes 1.
- Memory select at LAT=3:
  - Stimulus: `mem_r_en`=1, `mem_res`=0xDEAD_BEEF, `dest`=14.
  - Response: output appears exactly 3 cycles later, with `wb_value`=0xDEADBEEF.
- Sub-word loads (macro defined), with `mem_res`=0x80F1_7F82:
  - Byte, `addr_lo`=1, signed: `wb_value`=0x0000_007F.
  - Byte, `addr_lo`=0, signed: `wb_value`=0xFFFF_FF82.
  - Halfword, `addr_lo`=2, unsigned: `wb_value`=0x0000_80F1.
  - Halfword, `addr_lo`=2, signed: `wb_value`=0xFFFF_80F1.
  - Macro undefined: 0x80F17F82 for all of the above.
- Freeze:
  - Stimulus: stream of 3 writes; assert `freeze` for 4 cycles mid-stream.
  - Response: outputs stay constant and `commit_cnt` does not advance. After release, the remaining writes emerge in order and the final `commit_cnt`=3.
- Flush priority:
  - Stimulus: LAT=2, two valid writes in flight; assert `flush` and `freeze` together for one cycle.
  - Response: `wb_valid`=0 the next cycle, and no further writes emerge. `commit_cnt` is unchanged.
- Wrap and mid-stream reset:
  - Stimulus: CNT_W=4, 17 committed writes.
  - Response: `commit_cnt`=1.
  - Then assert `rst` with writes in flight: all outputs read 0 on the next cycle.
